// File: rtl/divisor_pkg.sv
// divisor_pkg: shared defaults and channel-state type for divisor_frecuencia_prog.
package divisor_pkg;

    localparam int DIV_WIDTH        = 25;
    localparam int DIV_DEFAULT_HALF = 250000;

    typedef struct packed {
        logic [DIV_WIDTH-1:0] half;
        logic [DIV_WIDTH-1:0] cnt;
        logic                 level;
    } canal_st_t;

endpackage

// File: rtl/divisor_canal.sv
// divisor_canal: one divider channel producing a square wave and a tick strobe.
// DIVISOR_DEFERRED_LOAD_EN defers half-period reloads to the next terminal count.
module divisor_canal import divisor_pkg::*; #(
    parameter int WIDTH        = DIV_WIDTH,
    parameter int DEFAULT_HALF = DIV_DEFAULT_HALF
) (
    input  logic             clk_interno,
    input  logic             reset,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [WIDTH-1:0] cfg_half_i,
    output logic             clk_deseado_o,
    output logic             tick_o,
    output logic             cfg_pend_o
);

    logic [WIDTH-1:0] half_q, half_d, cnt_q, cnt_d;
    logic             level_q, level_d, tick_q, tick_d;
    logic             stopped, tc;

    assign stopped = half_q == '0;
    assign tc      = en_i && !stopped && cnt_q == half_q - WIDTH'(1);

`ifdef DIVISOR_DEFERRED_LOAD_EN
    logic [WIDTH-1:0] pend_half_q, pend_half_d;
    logic             pend_q, pend_d, load;

    // a write landing on the terminal count stays pending for the following one
    always_comb begin
        load        = pend_q && !we_i && (tc || stopped);
        half_d      = load ? pend_half_q : half_q;
        pend_half_d = we_i ? cfg_half_i : pend_half_q;
        pend_d      = we_i || (pend_q && !load);
        cnt_d       = (tc || stopped) ? '0 : en_i ? cnt_q + WIDTH'(1) : cnt_q;
        level_d     = stopped ? 1'b0 : level_q ^ tc;
        tick_d      = tc;
    end

    always_ff @(posedge clk_interno) begin
        if (reset) begin
            pend_half_q <= '0;
            pend_q      <= 1'b0;
        end else begin
            pend_half_q <= pend_half_d;
            pend_q      <= pend_d;
        end
    end

    assign cfg_pend_o = pend_q;
`else
    // an immediate write restarts the count and swallows a coincident toggle
    always_comb begin
        half_d  = we_i ? cfg_half_i : half_q;
        cnt_d   = (we_i || tc || stopped) ? '0 : en_i ? cnt_q + WIDTH'(1) : cnt_q;
        level_d = we_i ? level_q : stopped ? 1'b0 : level_q ^ tc;
        tick_d  = tc && !we_i;
    end

    assign cfg_pend_o = 1'b0;
`endif

    always_ff @(posedge clk_interno) begin
        if (reset) begin
            half_q  <= WIDTH'(DEFAULT_HALF);
            cnt_q   <= '0;
            level_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            half_q  <= half_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            tick_q  <= tick_d;
        end
    end

    assign clk_deseado_o = level_q;
    assign tick_o        = tick_q;

endmodule

// File: rtl/divisor_frecuencia_prog.sv
// divisor_frecuencia_prog: N_CH programmable clock-enable / square-wave generators.
// Build with DIVISOR_DEFERRED_LOAD_EN for glitch-free deferred reload.
module divisor_frecuencia_prog import divisor_pkg::*; #(
    parameter int N_CH         = 2,
    parameter int WIDTH        = DIV_WIDTH,
    parameter int DEFAULT_HALF = DIV_DEFAULT_HALF,
    parameter int SEL_W        = 3
) (
    input  logic             clk_interno,
    input  logic             reset,
    input  logic [N_CH-1:0]  en,
    input  logic             cfg_we,
    input  logic [SEL_W-1:0] cfg_sel,
    input  logic [WIDTH-1:0] cfg_half,
    output logic [N_CH-1:0]  clk_deseado,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  cfg_pend
);

    // out-of-range selects match no channel, so such writes vanish
    for (genvar c = 0; c < N_CH; c++) begin : g_canal
        divisor_canal #(
            .WIDTH        (WIDTH),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_canal (
            .clk_interno   (clk_interno),
            .reset         (reset),
            .en_i          (en[c]),
            .we_i          (cfg_we && cfg_sel == SEL_W'(c)),
            .cfg_half_i    (cfg_half),
            .clk_deseado_o (clk_deseado[c]),
            .tick_o        (tick[c]),
            .cfg_pend_o    (cfg_pend[c])
        );
    end

endmodule

// File: tb/tb_divisor_frecuencia_prog.sv
// tb_divisor_frecuencia_prog: scoreboard bench on a reduced build (DEFAULT_HALF=4, WIDTH=8).
module tb_divisor_frecuencia_prog;

    localparam int N = 2;
    localparam int W = 8;
    localparam int S = 3;

    logic         clk = 1'b0;
    logic         rst, cfg_we;
    logic [N-1:0] en, cd, tk, pd;
    logic [S-1:0] sel;
    logic [W-1:0] half;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;

    typedef struct {
        int         cyc;
        string      name;
        logic [1:0] m, cd, tk, pd;
    } exp_t;

    exp_t q[$];

    divisor_frecuencia_prog #(
        .N_CH(N), .WIDTH(W), .DEFAULT_HALF(4), .SEL_W(S)
    ) dut (
        .clk_interno (clk),
        .reset       (rst),
        .en          (en),
        .cfg_we      (cfg_we),
        .cfg_sel     (sel),
        .cfg_half    (half),
        .clk_deseado (cd),
        .tick        (tk),
        .cfg_pend    (pd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // wait for the next edge, then queue what that edge must have produced
    task automatic step(input string name, input logic [1:0] m, input logic [1:0] cd_e,
                        input logic [1:0] tk_e, input logic [1:0] pd_e);
        exp_t e;
        @(posedge clk);
        #1;
        e.cyc = cyc;
        e.name = name;
        e.m = m;
        e.cd = cd_e;
        e.tk = tk_e;
        e.pd = pd_e;
        q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc || ((cd ^ e.cd) & e.m) != 0 || ((tk ^ e.tk) & e.m) != 0
                || ((pd ^ e.pd) & e.m) != 0) begin
                errors++;
                $display("FAIL %s cyc=%0d: clk_deseado=%b tick=%b cfg_pend=%b required %b %b %b (mask %b)",
                         e.name, cyc, cd, tk, pd, e.cd, e.tk, e.pd, e.m);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = '0; cfg_we = 1'b0; sel = '0; half = '0;
        step("reset", 2'b11, 2'b00, 2'b00, 2'b00);
        step("reset", 2'b11, 2'b00, 2'b00, 2'b00);
        rst = 1'b0; en = 2'b11;
        for (int e = 1; e <= 12; e++)
            step("default_half", 2'b11, ((e / 4) % 2) != 0 ? 2'b11 : 2'b00,
                 (e % 4) == 0 ? 2'b11 : 2'b00, 2'b00);
        cfg_we = 1'b1; sel = 3'd1; half = 8'd1;
        step("wr_ch1_half1", 2'b11, 2'b11, 2'b00, 2'b00);
        cfg_we = 1'b0;
        step("half1", 2'b11, 2'b01, 2'b10, 2'b00);
        step("half1", 2'b11, 2'b11, 2'b10, 2'b00);
        step("half1", 2'b11, 2'b00, 2'b11, 2'b00);
        step("half1", 2'b11, 2'b10, 2'b10, 2'b00);
        cfg_we = 1'b1; sel = 3'd1; half = 8'd0;
        step("wr_ch1_half0", 2'b11, 2'b10, 2'b00, 2'b00);
        cfg_we = 1'b0;
        step("half0", 2'b11, 2'b00, 2'b00, 2'b00);
        step("half0", 2'b11, 2'b01, 2'b01, 2'b00);
        step("half0", 2'b11, 2'b01, 2'b00, 2'b00);
        step("cnt2", 2'b11, 2'b01, 2'b00, 2'b00);
        en = 2'b10;
        repeat (10) step("en_off", 2'b11, 2'b01, 2'b00, 2'b00);
        en = 2'b11;
        step("resume", 2'b11, 2'b01, 2'b00, 2'b00);
        step("resume_tog", 2'b11, 2'b00, 2'b01, 2'b00);
        cfg_we = 1'b1; sel = 3'd5; half = 8'd1;
        step("sel5", 2'b11, 2'b00, 2'b00, 2'b00);
        cfg_we = 1'b0;
        step("sel5", 2'b11, 2'b00, 2'b00, 2'b00);
        step("sel5", 2'b11, 2'b00, 2'b00, 2'b00);
        step("sel5_tog", 2'b11, 2'b01, 2'b01, 2'b00);
`ifdef DIVISOR_DEFERRED_LOAD_EN
        step("defer", 2'b11, 2'b01, 2'b00, 2'b00);
        cfg_we = 1'b1; sel = 3'd0; half = 8'd2;
        step("defer_wr", 2'b11, 2'b01, 2'b00, 2'b01);
        cfg_we = 1'b0;
        step("defer_pend", 2'b11, 2'b01, 2'b00, 2'b01);
        step("defer_old", 2'b11, 2'b00, 2'b01, 2'b00);
        step("defer_new", 2'b11, 2'b00, 2'b00, 2'b00);
        step("defer_new", 2'b11, 2'b01, 2'b01, 2'b00);
        step("defer_new", 2'b11, 2'b01, 2'b00, 2'b00);
        step("defer_new", 2'b11, 2'b00, 2'b01, 2'b00);
        cfg_we = 1'b1; sel = 3'd0; half = 8'd3;
        step("pend_before_rst", 2'b11, 2'b00, 2'b00, 2'b01);
`else
        step("tc_wr", 2'b11, 2'b01, 2'b00, 2'b00);
        step("tc_wr", 2'b11, 2'b01, 2'b00, 2'b00);
        step("tc_wr", 2'b11, 2'b01, 2'b00, 2'b00);
        cfg_we = 1'b1; sel = 3'd0; half = 8'd2;
        step("tc_wr_wins", 2'b11, 2'b01, 2'b00, 2'b00);
        cfg_we = 1'b0;
        step("new_half", 2'b11, 2'b01, 2'b00, 2'b00);
        step("new_half", 2'b11, 2'b00, 2'b01, 2'b00);
        step("new_half", 2'b11, 2'b00, 2'b00, 2'b00);
        step("new_half", 2'b11, 2'b01, 2'b01, 2'b00);
        cfg_we = 1'b1; sel = 3'd0; half = 8'd3;
        step("wr_before_rst", 2'b11, 2'b01, 2'b00, 2'b00);
`endif
        cfg_we = 1'b0; rst = 1'b1;
        step("mid_reset", 2'b11, 2'b00, 2'b00, 2'b00);
        rst = 1'b0;
        step("after_rst", 2'b11, 2'b00, 2'b00, 2'b00);
        step("after_rst", 2'b11, 2'b00, 2'b00, 2'b00);
        step("after_rst", 2'b11, 2'b00, 2'b00, 2'b00);
        step("after_rst_tog", 2'b11, 2'b11, 2'b11, 2'b00);
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            errors += q.size();
            $display("FAIL scoreboard: %0d expectations unchecked, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
